uart_prog_loader: RTL

//  Bootloader stage between uart_rx and instruction memory of rv32i_top_Soc. While progEnB is low,

---
 rtl/uart_prog_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_prog_loader.sv
// UART bootloader stage: packs received bytes little-endian into 32-bit imem words,
// holds the core in reset while loading, flushes any partial word on release.
module uart_prog_loader #(
    parameter int MEM_WORDS = 8192,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              rstB,
    input  logic              progEnB,
    input  logic              rxDataEn,
    input  logic [7:0]        rxData,
    output logic              imemWrEn,
    output logic [ADDR_W-1:0] imemAddr,
    output logic [31:0]       imemWrData,
    output logic [3:0]        imemBe,
    output logic              echoEn,
    output logic [7:0]        echoData,
    output logic              coreRstB,
    output logic              progDone,
    output logic              overflow,
    output logic [ADDR_W+1:0] byteCnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
    localparam logic [ADDR_W+1:0] CNT_MAX   = '1;

    state_t            state_r;
    state_t            state_s;
    logic [1:0]        lane_r;
    logic [23:0]       buf_r;
    logic [ADDR_W-1:0] waddr_r;
    logic              mem_full_r;
    logic              accept_s;
    logic              restart_s;
    logic              flush_wr_s;

    // Byte enables for a partial word holding `lane` filled lanes.
    function automatic logic [3:0] partial_be(input logic [1:0] lane);
        logic [3:0] be;
        case (lane)
            2'd1:    be = 4'b0001;
            2'd2:    be = 4'b0011;
            2'd3:    be = 4'b0111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        restart_s  = 1'b0;
        flush_wr_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (progEnB) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_LOAD: begin
                accept_s = rxDataEn;
                if (progEnB) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                flush_wr_s = (lane_r != 2'd0) && !mem_full_r;
                state_s    = ST_DONE;
            end
            ST_DONE: begin
                if (!progEnB) begin
                    state_s   = ST_LOAD;
                    restart_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and core-release outputs, taken from the next state so
    // coreRstB drops on the same edge that samples progEnB low in DONE.
    always_ff @(posedge clk) begin
        if (!rstB) begin
            state_r  <= ST_IDLE;
            coreRstB <= 1'b0;
            progDone <= 1'b0;
        end else begin
            state_r  <= state_s;
            coreRstB <= (state_s == ST_DONE);
            progDone <= (state_s == ST_DONE);
        end
    end

    // Byte assembly, imem write port, echo and session counters.
    always_ff @(posedge clk) begin
        if (!rstB) begin
            lane_r     <= 2'd0;
            buf_r      <= 24'h0;
            waddr_r    <= '0;
            mem_full_r <= 1'b0;
            imemWrEn   <= 1'b0;
            imemAddr   <= '0;
            imemWrData <= 32'h0;
            imemBe     <= 4'h0;
            echoEn     <= 1'b0;
            echoData   <= 8'h00;
            overflow   <= 1'b0;
            byteCnt    <= '0;
        end else begin
            imemWrEn <= 1'b0;
            imemBe   <= 4'h0;
            echoEn   <= accept_s;
            if (restart_s) begin
                lane_r     <= 2'd0;
                buf_r      <= 24'h0;
                waddr_r    <= '0;
                mem_full_r <= 1'b0;
                overflow   <= 1'b0;
                byteCnt    <= '0;
            end else if (accept_s) begin
                echoData <= rxData;
                lane_r   <= lane_r + 2'd1;
                if (byteCnt != CNT_MAX) begin
                    byteCnt <= byteCnt + (ADDR_W+2)'(1);
                end
                if (mem_full_r) begin
                    overflow <= 1'b1;
                end else if (lane_r == 2'd3) begin
                    imemWrEn   <= 1'b1;
                    imemBe     <= 4'hF;
                    imemAddr   <= waddr_r;
                    imemWrData <= {rxData, buf_r};
                    if (waddr_r == LAST_ADDR) begin
                        mem_full_r <= 1'b1;
                    end else begin
                        waddr_r <= waddr_r + ADDR_W'(1);
                    end
                end else begin
                    case (lane_r)
                        2'd0:    buf_r[7:0]   <= rxData;
                        2'd1:    buf_r[15:8]  <= rxData;
                        default: buf_r[23:16] <= rxData;
                    endcase
                end
            end else if (flush_wr_s) begin
                // Stale bytes from an earlier word may sit in unfilled lanes.
                imemWrEn   <= 1'b1;
                imemBe     <= partial_be(lane_r);
                imemAddr   <= waddr_r;
                imemWrData <= {8'h00, buf_r} & be_to_mask(partial_be(lane_r));
                lane_r     <= 2'd0;
            end
        end
    end

endmodule
